hour_disp_scan: RTL
===================

// Module: hour_disp_scan
// PURPOSE
//  Display end of the hour-counter BCD interface. Samples tens/ones hour digits
//  (h10/h1, 00..23), validates them and optionally converts them to 12-hour form
//  with AM/PM. Drives a 2-digit multiplexed 7-segment display via a scan FSM
//  with blanking gaps. Sits between the hour counter and the board LEDs.
// PARAMETERS
//  SCAN_DIV   1000  in_clk cycles each digit is lit (>=2)
//  BLANK_CYC  8     in_clk cycles all digits off between digits (>=1)
//  BLANK_LZ   1     1 = blank a zero tens digit in 12h mode; 0 = show it
// PORTS
//  in_clk  in   1  clock, all state on rising edge
//  rst     in   1  asynchronous, active-high reset
//  h1      in   4  BCD ones-of-hour from counter
//  h10     in   4  BCD tens-of-hour from counter
//  mode12  in   1  1 = 12h display, 0 = 24h display
//  seg     out  7  {g,f,e,d,c,b,a}, 1 = segment lit
//  an      out  2  digit enable, an[0] = ones, an[1] = tens, 1 = on
//  pm      out  1  12h mode: 1 = PM; 24h mode: 0
//  err     out  1  1 = sampled hour invalid
// BEHAVIOUR
//  - Reset (async, rst=1): state=GAP0, prescaler=0, sample regs=0,
//    seg=0, an=0, pm=0, err=0. Held while rst=1; exits on first edge after release.
//  - FSM: GAP0 -> ONES -> GAP1 -> TENS -> GAP0 ...
//    ONES/TENS last SCAN_DIV cycles; GAP0/GAP1 last BLANK_CYC cycles.
//    Prescaler counts 0..len-1 per state and clears on each transition.
//    Frame = 2*(SCAN_DIV+BLANK_CYC) cycles.
//  - Sampling: h1, h10 and mode12 are captured on the GAP0->ONES transition only.
//    Both digits of one frame always come from one sample (no tearing).
//    Input changes mid-frame are ignored until the next frame.
//  - Validity: invalid if h1>9, h10>2, or h10==2 && h1>3.
//    If invalid: err=1, both digits show dash (7'h40), pm=0.
//  - 24h: tens=h10, ones=h1, pm=0.
//  - 12h: value H=10*h10+h1.
//    H=0 -> 12, pm=0. H=1..11 -> H, pm=0. H=12 -> 12, pm=1.
//    H=13..23 -> H-12, pm=1.
//    Tens digit 0 is blank (7'h00) when BLANK_LZ=1.
//    24h mode never blanks.
//  - Decode: 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F; dash = 40; blank = 00.
//  - Outputs are registered, 1 cycle behind state.
//    In ONES: an=2'b01, seg=ones glyph. In TENS: an=2'b10, seg=tens glyph.
//    In GAP0/GAP1: an=2'b00, seg=7'h00.
//    an is never 2'b11.
//  - pm and err update on the cycle after sampling and hold for the whole frame.
//  - Reset mid-scan: immediate blank (an=0, seg=0), restart from GAP0, and
//    discard the old sample.
// TESTING
//  1. rst pulse mid-TENS -> an=0, seg=0 same cycle; after release,
//     first ONES lit at cycle BLANK_CYC+1.
//  2. 24h, h10=2, h1=3 -> ONES seg=4F, TENS seg=5B, pm=0, err=0.
//  3. 12h, h10=0, h1=0 -> ONES seg=5B ('2'), TENS seg=06 ('1'), pm=0.
//  4. 12h, h10=1, h1=3, BLANK_LZ=1 -> ONES seg=06, TENS seg=00, pm=1.
//  5. h10=2, h1=5 -> err=1, both digits seg=40, pm=0.
//  6. Change h1 from 4 to 7 during GAP1 -> TENS digit unchanged this frame;
//     new value appears next ONES.

Source files
------------

// File: rtl/hour_disp_scan.sv
// hour_disp_scan
//   Display end of the hour counter. Samples the BCD hour digits once per
//   display frame, validates them, optionally converts them to 12-hour form
//   with an AM/PM flag, and scans a 2-digit multiplexed 7-segment display
//   with all-off blanking gaps between digits.
//
// Ports
//   in_clk  in   1  clock, all state on rising edge
//   rst     in   1  asynchronous active-high reset
//   h1      in   4  BCD ones-of-hour
//   h10     in   4  BCD tens-of-hour
//   mode12  in   1  1 = 12h display, 0 = 24h display
//   seg     out  7  {g,f,e,d,c,b,a}, 1 = lit
//   an      out  2  digit enable, an[0] = ones, an[1] = tens, 1 = on
//   pm      out  1  PM flag (12h mode only)
//   err     out  1  sampled hour invalid
module hour_disp_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 8,
    parameter int BLANK_LZ  = 1
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic [3:0] h1,
    input  logic [3:0] h10,
    input  logic       mode12,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       pm,
    output logic       err
);

    localparam int MAXL = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = $clog2(MAXL);

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    typedef enum logic [1:0] {GAP0, ONES, GAP1, TENS} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = GLYPH_BLANK;
        endcase
    endfunction

    state_t        state_p0, state_nxt;
    logic [CW-1:0] cnt_p0, cnt_nxt;
    logic          last_cnt;

    logic [3:0]    h1_p0, h10_p0;
    logic          m12_p0;

    logic          valid;
    logic [4:0]    hr;
    logic [4:0]    disp12;
    logic [3:0]    tens_d, ones_d;
    logic [6:0]    tens_g, ones_g;
    logic          pm_c;

    // ---- stage 0: scan FSM, prescaler and frame sample ----
    always_comb begin
        state_nxt = state_p0;
        last_cnt  = 1'b0;
        case (state_p0)
            ONES, TENS: last_cnt = (cnt_p0 == SCAN_LAST);
            default:    last_cnt = (cnt_p0 == BLANK_LAST);
        endcase
        cnt_nxt = last_cnt ? '0 : cnt_p0 + 1'b1;
        if (last_cnt) begin
            case (state_p0)
                GAP0:    state_nxt = ONES;
                ONES:    state_nxt = GAP1;
                GAP1:    state_nxt = TENS;
                default: state_nxt = GAP0;
            endcase
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state_p0 <= GAP0;
            cnt_p0   <= '0;
            h1_p0    <= '0;
            h10_p0   <= '0;
            m12_p0   <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            cnt_p0   <= cnt_nxt;
            // One sample per frame keeps both digits consistent.
            if (state_p0 == GAP0 && last_cnt) begin
                h1_p0  <= h1;
                h10_p0 <= h10;
                m12_p0 <= mode12;
            end
        end
    end

    // Glyphs from the frame sample.
    always_comb begin
        valid  = (h1_p0 <= 4'd9) && (h10_p0 <= 4'd2) &&
                 !((h10_p0 == 4'd2) && (h1_p0 > 4'd3));
        hr     = 5'(h10_p0) * 5'd10 + 5'(h1_p0);
        disp12 = hr;
        if (hr == 5'd0)
            disp12 = 5'd12;
        else if (hr > 5'd12)
            disp12 = hr - 5'd12;

        tens_d = h10_p0;
        ones_d = h1_p0;
        if (m12_p0) begin
            tens_d = (disp12 >= 5'd10) ? 4'd1 : 4'd0;
            ones_d = (disp12 >= 5'd10) ? 4'(disp12 - 5'd10) : 4'(disp12);
        end

        tens_g = seg7(tens_d);
        ones_g = seg7(ones_d);
        if (m12_p0 && tens_d == 4'd0 && BLANK_LZ != 0)
            tens_g = GLYPH_BLANK;
        if (!valid) begin
            tens_g = GLYPH_DASH;
            ones_g = GLYPH_DASH;
        end

        pm_c = valid && m12_p0 && (hr >= 5'd12);
    end

    // ---- stage 1: registered display outputs ----
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            seg <= '0;
            an  <= '0;
            pm  <= 1'b0;
            err <= 1'b0;
        end else begin
            pm  <= pm_c;
            err <= !valid;
            case (state_p0)
                ONES: begin
                    an  <= 2'b01;
                    seg <= ones_g;
                end
                TENS: begin
                    an  <= 2'b10;
                    seg <= tens_g;
                end
                default: begin
                    an  <= 2'b00;
                    seg <= GLYPH_BLANK;
                end
            endcase
        end
    end

endmodule
